multiple_sequencer: RTL

Register-list sequencer for the LM/SM (load/store multiple) instructions of the multicycle RISC core. It latches the 8-bit register mask from IR[8:15] and the base address from ra. It then steps through the selected registers lowest-index-first, presenting one register index and one memory address per transfer. It produces `flag_multiple`, the completion flag the main controller FSM polls in its LM/SM states.

---
 rtl/multiple_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/multiple_sequencer.sv
// multiple_sequencer
// Walks the LM/SM register mask lowest-index-first and issues one register
// index and one memory address per transfer. flag_multiple tells the main
// controller that the whole list has been moved.
module multiple_sequencer #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode_store,
    input  logic [NREG-1:0]            imm,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic                       advance,
    output logic [$clog2(NREG)-1:0]    reg_idx,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       xfer_valid,
    output logic                       rf_we,
    output logic                       mem_we,
    output logic                       busy,
    output logic                       flag_multiple,
    output logic [$clog2(NREG+1)-1:0]  xfer_count
);

    localparam int IDX_W = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [NREG-1:0]     mask_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                mode_store_q;
    logic [NREG-1:0]     mask_next;
    logic [IDX_W-1:0]    lowest_idx;

    // Priority encoder: index of the lowest set mask bit, 0 for an empty mask.
    always_comb begin
        lowest_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    end

    // Dropping the lowest set bit is the same as clearing bit reg_idx.
    assign mask_next = mask_q & (mask_q - NREG'(1));

    // Sequencer state: start always wins and reloads, advance steps one register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            mask_q       <= '0;
            addr_q       <= '0;
            mode_store_q <= 1'b0;
            xfer_count   <= '0;
        end else if (start) begin
            mask_q       <= imm;
            addr_q       <= base_addr;
            mode_store_q <= mode_store;
            xfer_count   <= '0;
            state        <= (imm != '0) ? RUN : DONE;
        end else begin
            case (state)
                RUN: begin
                    if (advance) begin
                        mask_q     <= mask_next;
                        addr_q     <= addr_q + ADDR_W'(1);
                        xfer_count <= xfer_count + 1'b1;
                        if (mask_next == '0) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so nothing flows straight from the inputs.
    always_comb begin
        reg_idx       = lowest_idx;
        mem_addr      = addr_q;
        busy          = (state == RUN);
        xfer_valid    = (state == RUN);
        rf_we         = (state == RUN) & ~mode_store_q;
        mem_we        = (state == RUN) & mode_store_q;
        flag_multiple = (state == DONE);
    end

endmodule
